acc_requant: RTL and testbench

Output-requantization stage downstream of the pipelined MAC. It takes finished Q.10 accumulator results (2*WIDTH wide), adds a per-output Q5.10 bias, optionally applies ReLU, and saturates to WIDTH-bit Q5.10. Results are buffered in a small FIFO and presented on a valid/ready stream to the next layer or the writeback logic. The MAC's `valid` has no backpressure, so this block absorbs stalls and flags any drops.

---
 rtl/acc_requant_pkg.sv | 14 +
 rtl/acc_requant_sync_fifo.sv | 56 +++++
 rtl/acc_requant.sv | 132 +++++++++++++
 tb/tb_acc_requant.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_requant_pkg.sv
// Shared Q5.10 fixed-point constants and stream payload types for the MAC datapath.
package acc_requant_pkg;

   localparam int unsigned Q_WIDTH = 16;
   localparam int unsigned Q_FRAC  = 10;
   localparam int          QMAX    = 32767;
   localparam int          QMIN    = -32768;

   typedef struct packed {
      logic               sat;
      logic [Q_WIDTH-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/acc_requant_sync_fifo.sv
// Synchronous FIFO with explicit occupancy count; a push into a full FIFO only lands with a pop.
module sync_fifo #(
   parameter int unsigned W     = 17,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [W-1:0]                 i_data,
   output logic [W-1:0]                 o_data,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/acc_requant.sv
// Accumulator requantization: bias add, optional ReLU, saturate to Q5.10, buffered valid/ready output.
module acc_requant
   import acc_requant_pkg::*;
#(
   parameter int unsigned WIDTH = Q_WIDTH,
   parameter int unsigned FRAC  = Q_FRAC,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [2*WIDTH-1:0]           in_data,
   input  logic [WIDTH-1:0]             bias,
   input  logic                         relu_en,
   output logic                         out_valid,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_sat,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   input  logic                         clear_ovf
);

   localparam int unsigned SW = 2*WIDTH + 1;
   localparam int unsigned CW = $clog2(DEPTH+1);

   localparam logic [SW-1:0]    L_SUM_MAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [SW-1:0]    L_SUM_MIN = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] L_OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] L_OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("acc_requant: DEPTH must be a power of two >= 2");
   end
   if (FRAC >= WIDTH) begin : g_bad_frac
      $error("acc_requant: FRAC must be smaller than WIDTH");
   end

   logic                r_a_valid;
   logic [SW-1:0]       r_a_sum;
   logic                r_a_relu;
   logic                r_b_valid;
   logic [WIDTH-1:0]    r_b_data;
   logic                r_b_sat;
   logic                r_overflow;

   logic [SW-1:0]       w_sum;
   logic [WIDTH-1:0]    w_b_data;
   logic                w_b_sat;
   logic [WIDTH:0]      w_head;
   logic                w_full;
   logic                w_empty;
   logic [CW-1:0]       w_count;
   logic                w_drop;

   // One extra bit of headroom means the bias add can never wrap.
   assign w_sum = {in_data[2*WIDTH-1], in_data}
                + {{(WIDTH+1){bias[WIDTH-1]}}, bias};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_valid <= 1'b0;
         r_a_sum   <= '0;
         r_a_relu  <= 1'b0;
      end else begin
         r_a_valid <= in_valid;
         if (in_valid) begin
            r_a_sum  <= w_sum;
            r_a_relu <= relu_en;
         end
      end
   end

   always_comb begin
      w_b_data = r_a_sum[WIDTH-1:0];
      w_b_sat  = 1'b0;
      if (r_a_relu && r_a_sum[SW-1]) begin
         w_b_data = '0;
      end else if (!r_a_sum[SW-1] && (r_a_sum > L_SUM_MAX)) begin
         w_b_data = L_OUT_MAX;
         w_b_sat  = 1'b1;
      end else if (r_a_sum[SW-1] && (r_a_sum < L_SUM_MIN)) begin
         w_b_data = L_OUT_MIN;
         w_b_sat  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_b_valid <= 1'b0;
         r_b_data  <= '0;
         r_b_sat   <= 1'b0;
      end else begin
         r_b_valid <= r_a_valid;
         if (r_a_valid) begin
            r_b_data <= w_b_data;
            r_b_sat  <= w_b_sat;
         end
      end
   end

   // Full implies non-empty, so a pop happens exactly when out_ready is high.
   assign w_drop = r_b_valid && w_full && !out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             r_overflow <= 1'b0;
      else if (w_drop)     r_overflow <= 1'b1;
      else if (clear_ovf)  r_overflow <= 1'b0;
   end

   sync_fifo #(
      .W     (WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_b_valid),
      .i_pop   (out_ready),
      .i_data  ({r_b_sat, r_b_data}),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign out_valid = !w_empty;
   assign out_data  = w_head[WIDTH-1:0];
   assign out_sat   = w_head[WIDTH];
   assign count     = w_count;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_acc_requant.sv
// Directed self-checking bench for acc_requant: arithmetic, ReLU, saturation, FIFO full/drop, reset.
module tb_acc_requant;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic [15:0] bias;
   logic        relu_en;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_sat;
   logic        out_ready;
   logic [2:0]  count;
   logic        overflow;
   logic        clear_ovf;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   acc_requant #(.WIDTH(16), .FRAC(10), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .bias      (bias),
      .relu_en   (relu_en),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_ready (out_ready),
      .count     (count),
      .overflow  (overflow),
      .clear_ovf (clear_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single result through an empty FIFO with out_ready=1; samples the head two edges after capture.
   task automatic run_single(input logic [31:0] d, input logic [15:0] b, input logic r,
                             output logic v, output logic [15:0] dat, output logic s);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = d;
      bias      = b;
      relu_en   = r;
      step();
      in_valid  = 1'b0;
      step();
      step();
      v   = out_valid;
      dat = out_data;
      s   = out_sat;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; bias = '0; relu_en = 1'b0;
      out_ready = 1'b0; clear_ovf = 1'b0;
      #2;
      tot_cnt++;
      if ({out_valid, out_data, out_sat, count, overflow} !== 21'd0)
         $display("FAIL reset_outputs: got v=%b d=%h s=%b c=%0d o=%b, want all 0",
                  out_valid, out_data, out_sat, count, overflow);
      else pass_cnt++;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      logic v; logic [15:0] d; logic s;
      run_single(32'd3072, 16'd512, 1'b0, v, d, s);
      tot_cnt++;
      if (v !== 1'b1 || d !== 16'd3584 || s !== 1'b0)
         $display("FAIL basic_bias_add: got v=%b d=%0d s=%b, want v=1 d=3584 s=0", v, d, s);
      else pass_cnt++;
      tot_cnt++;
      if (count !== 3'd0 || out_valid !== 1'b0)
         $display("FAIL basic_drained: got count=%0d v=%b, want 0 0", count, out_valid);
      else pass_cnt++;
   endtask

   task automatic test_relu();
      logic v; logic [15:0] d; logic s;
      run_single(-32'sd2048, 16'd0, 1'b1, v, d, s);
      tot_cnt++;
      if (v !== 1'b1 || d !== 16'h0000 || s !== 1'b0)
         $display("FAIL relu_neg: got v=%b d=%h s=%b, want v=1 d=0000 s=0", v, d, s);
      else pass_cnt++;
      run_single(-32'sd2048, 16'd0, 1'b0, v, d, s);
      tot_cnt++;
      if (v !== 1'b1 || d !== 16'hF800 || s !== 1'b0)
         $display("FAIL neg_passthru: got v=%b d=%h s=%b, want v=1 d=f800 s=0", v, d, s);
      else pass_cnt++;
      run_single(32'd1000, 16'hFC00, 1'b1, v, d, s);
      tot_cnt++;
      if (v !== 1'b1 || d !== 16'h0000 || s !== 1'b0)
         $display("FAIL relu_bias_neg: got v=%b d=%h s=%b, want v=1 d=0000 s=0", v, d, s);
      else pass_cnt++;
   endtask

   task automatic test_saturation();
      logic v; logic [15:0] d; logic s;
      run_single(32'd40000, 16'd0, 1'b0, v, d, s);
      tot_cnt++;
      if (v !== 1'b1 || d !== 16'h7FFF || s !== 1'b1)
         $display("FAIL sat_pos: got v=%b d=%h s=%b, want v=1 d=7fff s=1", v, d, s);
      else pass_cnt++;
      run_single(-32'sd40000, 16'd0, 1'b0, v, d, s);
      tot_cnt++;
      if (v !== 1'b1 || d !== 16'h8000 || s !== 1'b1)
         $display("FAIL sat_neg: got v=%b d=%h s=%b, want v=1 d=8000 s=1", v, d, s);
      else pass_cnt++;
      run_single(32'h7FFF_FFFF, 16'h7FFF, 1'b0, v, d, s);
      tot_cnt++;
      if (v !== 1'b1 || d !== 16'h7FFF || s !== 1'b1)
         $display("FAIL sat_nowrap: got v=%b d=%h s=%b, want v=1 d=7fff s=1", v, d, s);
      else pass_cnt++;
      run_single(32'd32767, 16'd0, 1'b0, v, d, s);
      tot_cnt++;
      if (v !== 1'b1 || d !== 16'h7FFF || s !== 1'b0)
         $display("FAIL edge_max: got v=%b d=%h s=%b, want v=1 d=7fff s=0", v, d, s);
      else pass_cnt++;
      run_single(-32'sd32768, 16'd0, 1'b0, v, d, s);
      tot_cnt++;
      if (v !== 1'b1 || d !== 16'h8000 || s !== 1'b0)
         $display("FAIL edge_min: got v=%b d=%h s=%b, want v=1 d=8000 s=0", v, d, s);
      else pass_cnt++;
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      bias = '0; relu_en = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         in_valid = 1'b1;
         in_data  = 32'(i);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      tot_cnt++;
      if (count !== 3'd4 || overflow !== 1'b1 || out_valid !== 1'b1)
         $display("FAIL ovf_full: got count=%0d ovf=%b v=%b, want 4 1 1", count, overflow, out_valid);
      else pass_cnt++;
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tot_cnt++;
         if (out_valid !== 1'b1 || out_data !== 16'(i) || out_sat !== 1'b0)
            $display("FAIL ovf_drain_%0d: got v=%b d=%0d s=%b, want v=1 d=%0d s=0",
                     i, out_valid, out_data, out_sat, i);
         else pass_cnt++;
         step();
      end
      tot_cnt++;
      if (count !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b1)
         $display("FAIL ovf_empty: got count=%0d v=%b ovf=%b, want 0 0 1", count, out_valid, overflow);
      else pass_cnt++;
      clear_ovf = 1'b1;
      step();
      clear_ovf = 1'b0;
      tot_cnt++;
      if (overflow !== 1'b0)
         $display("FAIL ovf_clear: got ovf=%b, want 0", overflow);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      bias = '0; relu_en = 1'b0;
      // Values 10..21 sampled on consecutive edges e0..e11; FIFO fills at e5, then push+pop each edge.
      for (int i = 0; i < 14; i++) begin
         in_valid = (i < 12);
         in_data  = 32'(10 + i);
         step();
         if (i == 5) out_ready = 1'b1;
         if (i >= 5) begin
            tot_cnt++;
            if (count !== 3'd4 || overflow !== 1'b0 || out_data !== 16'(10 + i - 5))
               $display("FAIL b2b_full_e%0d: got count=%0d ovf=%b d=%0d, want 4 0 %0d",
                        i, count, overflow, out_data, 10 + i - 5);
            else pass_cnt++;
         end
      end
      in_valid = 1'b0;
      for (int k = 18; k <= 21; k++) begin
         tot_cnt++;
         if (out_valid !== 1'b1 || out_data !== 16'(k))
            $display("FAIL b2b_drain_%0d: got v=%b d=%0d, want v=1 d=%0d", k, out_valid, out_data, k);
         else pass_cnt++;
         step();
      end
      tot_cnt++;
      if (count !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0)
         $display("FAIL b2b_end: got count=%0d v=%b ovf=%b, want 0 0 0", count, out_valid, overflow);
      else pass_cnt++;
   endtask

   task automatic test_reset_midstream();
      logic v; logic [15:0] d; logic s;
      out_ready = 1'b0;
      bias = '0; relu_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 32'(30 + i);
         step();
      end
      in_valid = 1'b0;
      tot_cnt++;
      if (count !== 3'd3 || out_data !== 16'd30)
         $display("FAIL rst_pre: got count=%0d d=%0d, want 3 30", count, out_data);
      else pass_cnt++;
      rst = 1'b1;
      #1;
      tot_cnt++;
      if ({out_valid, out_data, out_sat, count, overflow} !== 21'd0)
         $display("FAIL rst_mid_outputs: got v=%b d=%h s=%b c=%0d o=%b, want all 0",
                  out_valid, out_data, out_sat, count, overflow);
      else pass_cnt++;
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         tot_cnt++;
         if (out_valid !== 1'b0 || count !== 3'd0)
            $display("FAIL rst_no_spurious_%0d: got v=%b count=%0d, want 0 0", i, out_valid, count);
         else pass_cnt++;
      end
      run_single(32'd1024, 16'd1024, 1'b0, v, d, s);
      tot_cnt++;
      if (v !== 1'b1 || d !== 16'd2048 || s !== 1'b0)
         $display("FAIL rst_resume: got v=%b d=%0d s=%b, want v=1 d=2048 s=0", v, d, s);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_relu();
      test_saturation();
      test_overflow();
      test_back_to_back();
      test_reset_midstream();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
